// File: rtl/alu_pkg.sv
// Shared ALU op encodings, LFSR polynomial and BIST state type.
// Used by the ALU itself and by its built-in self-test engine.
package alu_pkg;

   localparam logic [3:0]  ALU_AND   = 4'b0000;
   localparam logic [3:0]  ALU_OR    = 4'b0001;
   localparam logic [3:0]  ALU_ADD   = 4'b0010;
   localparam logic [3:0]  ALU_SUB   = 4'b0110;
   localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_APPLY = 2'd1,
      ST_CHECK = 2'd2,
      ST_DONE  = 2'd3
   } bist_state_e;

   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
   endfunction

   // Ops are swept in the fixed order AND, OR, ADD, SUB.
   function automatic logic [3:0] op_at(input logic [1:0] idx);
      case (idx)
         2'd0:    return ALU_AND;
         2'd1:    return ALU_OR;
         2'd2:    return ALU_ADD;
         default: return ALU_SUB;
      endcase
   endfunction

   function automatic logic [31:0] alu_result(input logic [3:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
      case (op)
         ALU_AND: return a & b;
         ALU_OR:  return a | b;
         ALU_ADD: return a + b;
         ALU_SUB: return a - b;
         default: return 32'h0;
      endcase
   endfunction

endpackage

// File: rtl/alu_bist_if.sv
// Operand/control bus between the self-test engine (master) and the ALU (slave).
interface alu_bist_if;
   logic [3:0]  alu_control_op_o;
   logic [31:0] a_num_o;
   logic [31:0] b_num_o;
   logic [31:0] c_num_i;
   logic        zero_i;

   modport master (
      output alu_control_op_o, a_num_o, b_num_o,
      input  c_num_i, zero_i
   );

   modport slave (
      input  alu_control_op_o, a_num_o, b_num_o,
      output c_num_i, zero_i
   );
endinterface

// File: rtl/lfsr32.sv
// 32-bit right-shift Galois LFSR with seed load; a zero seed is forced to 1.
// Latency: value updates on the edge after load/step. No backpressure.
module lfsr32
   import alu_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        load_i,
   input  logic [31:0] seed_i,
   input  logic        step_i,
   output logic [31:0] value_o
);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         value_o <= 32'h0;
      end else if (load_i) begin
         value_o <= (seed_i == 32'h0) ? 32'h1 : seed_i;
      end else if (step_i) begin
         value_o <= lfsr_next(value_o);
      end
   end

endmodule

// File: rtl/alu_bist.sv
// ALU self-test: sweeps LFSR operand pairs through AND/OR/ADD/SUB and counts mismatches.
// Latency: 2 cycles per op, 8 per vector, done 8*NUM_VECTORS edges after start.
// Backpressure: none; start is ignored while a run is in progress.
module alu_bist
   import alu_pkg::*;
#(
   parameter int unsigned NUM_VECTORS = 1000,
   parameter logic [31:0] SEED_A      = 32'hACE1_2468,
   parameter logic [31:0] SEED_B      = 32'h1357_BDF0
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        start_i,
   alu_bist_if.master  alu,
   output logic        busy_o,
   output logic        done_o,
   output logic        pass_o,
   output logic [15:0] error_count_o,
   output logic [3:0]  fail_op_o,
   output logic [31:0] fail_a_o,
   output logic [31:0] fail_b_o
);

   localparam logic [15:0] LAST_VEC = 16'(NUM_VECTORS - 1);

   bist_state_e state_q, state_d;
   logic [3:0]  op_q;
   logic [1:0]  op_idx_q;
   logic [15:0] vec_cnt_q;
   logic        fail_seen_q;
   logic [31:0] a_val, b_val;

   logic        load_run, step_lfsr, check_en, advance_op, run_end;
   logic [31:0] expected;
   logic        mismatch;
   logic [15:0] err_next;

   lfsr32 u_lfsr_a (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .load_i  (load_run),
      .seed_i  (SEED_A),
      .step_i  (step_lfsr),
      .value_o (a_val)
   );

   lfsr32 u_lfsr_b (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .load_i  (load_run),
      .seed_i  (SEED_B),
      .step_i  (step_lfsr),
      .value_o (b_val)
   );

   assign alu.alu_control_op_o = op_q;
   assign alu.a_num_o          = a_val;
   assign alu.b_num_o          = b_val;

   // Response compare only feeds registers, never an output directly.
   assign expected = alu_result(op_q, a_val, b_val);
   assign mismatch = (alu.c_num_i != expected) || (alu.zero_i != (expected == 32'h0));
   assign err_next = (mismatch && (error_count_o != 16'hFFFF)) ? error_count_o + 16'd1
                                                                : error_count_o;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      load_run   = 1'b0;
      step_lfsr  = 1'b0;
      check_en   = 1'b0;
      advance_op = 1'b0;
      run_end    = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_i) begin
               load_run = 1'b1;
               state_d  = ST_APPLY;
            end
         end
         ST_APPLY: state_d = ST_CHECK;
         ST_CHECK: begin
            check_en = 1'b1;
            if (op_idx_q != 2'd3) begin
               advance_op = 1'b1;
               state_d    = ST_APPLY;
            end else if (vec_cnt_q == LAST_VEC) begin
               run_end = 1'b1;
               state_d = ST_DONE;
            end else begin
               step_lfsr = 1'b1;
               state_d   = ST_APPLY;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         op_q          <= ALU_AND;
         op_idx_q      <= 2'd0;
         vec_cnt_q     <= 16'd0;
         fail_seen_q   <= 1'b0;
         busy_o        <= 1'b0;
         done_o        <= 1'b0;
         pass_o        <= 1'b0;
         error_count_o <= 16'd0;
         fail_op_o     <= 4'd0;
         fail_a_o      <= 32'h0;
         fail_b_o      <= 32'h0;
      end else begin
         if (load_run) begin
            op_q          <= ALU_AND;
            op_idx_q      <= 2'd0;
            vec_cnt_q     <= 16'd0;
            fail_seen_q   <= 1'b0;
            busy_o        <= 1'b1;
            done_o        <= 1'b0;
            pass_o        <= 1'b0;
            error_count_o <= 16'd0;
            fail_op_o     <= 4'd0;
            fail_a_o      <= 32'h0;
            fail_b_o      <= 32'h0;
         end
         if (check_en) begin
            error_count_o <= err_next;
            if (mismatch && !fail_seen_q) begin
               fail_seen_q <= 1'b1;
               fail_op_o   <= op_q;
               fail_a_o    <= a_val;
               fail_b_o    <= b_val;
            end
         end
         if (advance_op) begin
            op_idx_q <= op_idx_q + 2'd1;
            op_q     <= op_at(op_idx_q + 2'd1);
         end
         if (step_lfsr) begin
            op_idx_q  <= 2'd0;
            op_q      <= ALU_AND;
            vec_cnt_q <= vec_cnt_q + 16'd1;
         end
         if (run_end) begin
            busy_o <= 1'b0;
            done_o <= 1'b1;
            pass_o <= (err_next == 16'd0);
         end
      end
   end

endmodule
